hram_cfgreg_wr_seq: RTL
=======================

Name: hram_cfgreg_wr_seq

Overview:
Sequencer for HyperRAM configuration-register writes (CR0/CR1), issued on a CSR write. It sits directly downstream of the top-level dispatcher, which raises its `stm_start` and waits for `stm_end`. It produces the `csn`, `oe`, `oe_clk` and `datain` stream that the dispatcher muxes onto the HyperRAM pads. Register writes are zero-latency: the 3-word command/address (CA) is followed immediately by one data word, and `rwds` is never driven.

Parameters:
CSS_CYC, 1, cycles with csn low and clock gated before the first CA word (1..15)
CSH_CYC, 1, cycles with csn held low after the data word, clock gated (1..15)
RWR_CYC, 6, csn-high recovery cycles before completion is reported (1..15)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
stm_start  input  1  level request from dispatcher; held high until stm_end is seen
stm_end  output  1  completion; high until stm_start is sampled low
reg_addr  input  10  CSR byte address; sampled when a transaction is accepted
reg_wdata  input  32  CSR write data; bits [15:0] are written, sampled with reg_addr
oe  output  1  data-bus output enable
oe_clk  output  1  HyperRAM clock enable
csn  output  1  chip select, active low
datain  output  16  word driven onto the DQ bus
wr_err  output  1  sticky; set when the accepted address is not writable; cleared at the next acceptance

Behaviour:
- All outputs are registered and update on the same edge as the state register.
- Reset (rst=0, asynchronous): state=IDLE, csn=1, oe=0, oe_clk=0, datain=0, stm_end=0, wr_err=0, counter=0.
- Address decode, latched at acceptance:
  - 'h8 -> CA=48'h6000_0100_0000 (CR0).
  - 'hc -> CA=48'h6000_0100_0001 (CR1).
  - Any other address (including ID0 'h0 and ID1 'h4): invalid.
- IDLE: csn=1, oe=0, oe_clk=0.
  - stm_start=1 and address valid: latch CA and wdata[15:0], clear wr_err, go to CSS. csn goes low on this edge.
  - stm_start=1 and address invalid: set wr_err, go to DONE. No bus activity.
- CSS: csn=0, oe=0, oe_clk=0 for CSS_CYC cycles (down-counter), then CA0.
- CA0, CA1, CA2: one cycle each. csn=0, oe=1, oe_clk=1. datain = CA[47:32], CA[31:16], CA[15:0] respectively.
- DATA: one cycle. csn=0, oe=1, oe_clk=1, datain=wdata[15:0].
- CSH: csn=0, oe=0, oe_clk=0, datain=0 for CSH_CYC cycles, then RWR.
- RWR: csn=1, all enables 0, for RWR_CYC cycles, then DONE.
- DONE: stm_end=1. Leave to IDLE (stm_end=0) on the first edge where stm_start=0.
- Latency with defaults, counted from the accepting edge: 12 cycles to DONE. csn is low for exactly 6 cycles; oe and oe_clk are high for exactly 4 consecutive cycles.
- Abort: stm_start=0 in CSS, CA0..2, DATA or CSH goes to RWR on the next edge. csn goes high, enables drop, and the write is not completed. After RWR, return to IDLE without asserting stm_end.
- stm_start=0 during RWR: recovery still completes; go to IDLE, not DONE.
- stm_start held high in DONE: stay in DONE, no re-trigger. A new transaction needs stm_start low for at least 1 cycle.
- reg_addr and reg_wdata changes after acceptance have no effect.
- Mid-operation reset: outputs take reset values immediately, with no wait for a clock edge.

Test Plan:
- Reset released, stm_start=0 for 10 cycles -> csn=1, oe=0, oe_clk=0, stm_end=0 throughout.
- reg_addr='h8, reg_wdata=32'h0000_8F1F, start held -> after csn falls: datain sequence 6000, 0100, 0000, 8F1F with oe=oe_clk=1 for exactly those 4 cycles; csn low 6 cycles; stm_end at cycle 12; wr_err=0.
- reg_addr='hc, reg_wdata=32'hABCD_0002, RWR_CYC=3 -> datain 6000, 0100, 0001, 0002; stm_end at cycle 9; upper data bits never driven.
- reg_addr='h4 -> no csn activity, stm_end=1 one cycle after acceptance, wr_err=1. A following valid 'h8 write clears wr_err.
- stm_start dropped during CA1 -> csn=1 next cycle, oe=0, 6 recovery cycles, IDLE, stm_end never asserted.
- rst asserted during DATA, asynchronously between edges -> csn=1, oe=0, oe_clk=0 immediately. After release, a new 'h8 write completes normally.

Source files
------------

// File: rtl/hram_cfgreg_wr_seq_if.sv
// Dispatcher <-> CR-write sequencer bundle: start/end handshake, CSR write operands, pad drive stream.
// Combinational wiring only; the handshake is a held level request answered by a held completion.
interface hram_cfgreg_wr_seq_if;
    logic        stm_start;
    logic        stm_end;
    logic [9:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        oe;
    logic        oe_clk;
    logic        csn;
    logic [15:0] datain;
    logic        wr_err;

    modport master (
        output stm_start, reg_addr, reg_wdata,
        input  stm_end, oe, oe_clk, csn, datain, wr_err
    );

    modport slave (
        input  stm_start, reg_addr, reg_wdata,
        output stm_end, oe, oe_clk, csn, datain, wr_err
    );
endinterface

// File: rtl/hram_cfgreg_wr_seq.sv
// HyperRAM CR0/CR1 write sequencer: CSS, 3 CA words, 1 data word, CSH, recovery; registered outputs.
// 12 cycles accept-to-stm_end with defaults; dropping stm_start aborts to recovery, stm_end held until start falls.
module hram_cfgreg_wr_seq #(
    parameter int unsigned CSS_CYC = 1,
    parameter int unsigned CSH_CYC = 1,
    parameter int unsigned RWR_CYC = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    hram_cfgreg_wr_seq_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, CSS, CA0, CA1, CA2, DATA, CSH, RWR, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic [15:0] wdat_q, wdat_d;
    logic        abort_q, abort_d;
    logic        wr_err_q, wr_err_d;
    logic        csn_q, csn_d;
    logic        oe_q, oe_d;
    logic        stm_end_q, stm_end_d;
    logic [15:0] datain_q, datain_d;
    logic        addr_ok;

    // Only the low data half reaches the register; the upper half is ignored.
    logic        unused_wdata_hi;
    assign unused_wdata_hi = ^bus.reg_wdata[31:16];

    assign addr_ok = (bus.reg_addr == 10'h008) || (bus.reg_addr == 10'h00c);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        abort_d   = abort_q;
        wr_err_d  = wr_err_q;
        case (state_q)
            IDLE: begin
                if (bus.stm_start) begin
                    if (addr_ok) begin
                        sel_d    = bus.reg_addr[2];
                        wdat_d   = bus.reg_wdata[15:0];
                        wr_err_d = 1'b0;
                        abort_d  = 1'b0;
                        cnt_d    = 4'(CSS_CYC - 1);
                        state_d  = CSS;
                    end else begin
                        wr_err_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            CSS, CA0, CA1, CA2, DATA, CSH: begin
                if (!bus.stm_start) begin
                    abort_d = 1'b1;
                    cnt_d   = 4'(RWR_CYC - 1);
                    state_d = RWR;
                end else begin
                    case (state_q)
                        CSS: begin
                            if (cnt_q == 4'd0) state_d = CA0;
                            else               cnt_d   = cnt_q - 4'd1;
                        end
                        CA0:  state_d = CA1;
                        CA1:  state_d = CA2;
                        CA2:  state_d = DATA;
                        DATA: begin
                            cnt_d   = 4'(CSH_CYC - 1);
                            state_d = CSH;
                        end
                        default: begin
                            if (cnt_q == 4'd0) begin
                                cnt_d   = 4'(RWR_CYC - 1);
                                state_d = RWR;
                            end else begin
                                cnt_d   = cnt_q - 4'd1;
                            end
                        end
                    endcase
                end
            end
            RWR: begin
                // Recovery always runs to the end; a dropped request only redirects the exit.
                if (!bus.stm_start) abort_d = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = (abort_q || !bus.stm_start) ? IDLE : DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                if (!bus.stm_start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        csn_d     = 1'b1;
        oe_d      = 1'b0;
        stm_end_d = 1'b0;
        datain_d  = 16'h0000;
        case (state_d)
            CSS, CSH: csn_d = 1'b0;
            CA0: begin csn_d = 1'b0; oe_d = 1'b1; datain_d = 16'h6000;          end
            CA1: begin csn_d = 1'b0; oe_d = 1'b1; datain_d = 16'h0100;          end
            CA2: begin csn_d = 1'b0; oe_d = 1'b1; datain_d = {15'h0000, sel_d}; end
            DATA: begin csn_d = 1'b0; oe_d = 1'b1; datain_d = wdat_d;           end
            DONE: stm_end_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sel_q     <= 1'b0;
            wdat_q    <= 16'h0000;
            abort_q   <= 1'b0;
            wr_err_q  <= 1'b0;
            csn_q     <= 1'b1;
            oe_q      <= 1'b0;
            stm_end_q <= 1'b0;
            datain_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            abort_q   <= abort_d;
            wr_err_q  <= wr_err_d;
            csn_q     <= csn_d;
            oe_q      <= oe_d;
            stm_end_q <= stm_end_d;
            datain_q  <= datain_d;
        end
    end

    assign bus.csn     = csn_q;
    assign bus.oe      = oe_q;
    assign bus.oe_clk  = oe_q;
    assign bus.datain  = datain_q;
    assign bus.stm_end = stm_end_q;
    assign bus.wr_err  = wr_err_q;

endmodule
